debounce_pulse: RTL and testbench

Input conditioning stage directly upstream of the team's 3-bit counter. Takes a raw, asynchronous, bouncing push-button level and synchronises it to clk. It then debounces it and emits a single-cycle press pulse, intended as the counter's count-enable, plus a release pulse and a clean debounced level. One accepted physical press produces exactly one pulse.

---
 rtl/debounce_pulse.sv | 114 +++++++++++
 tb/tb_debounce_pulse.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_pulse.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, and registered
// single-cycle press/release pulses with a clean debounced level.
module debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 4,  // legal range 1 .. 2**CNT_W-1
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic level
);

  typedef enum logic [1:0] {
    IDLE,
    ARM_PRESS,
    HELD,
    ARM_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic sync_1, sync_2, btn_s;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic press_nxt, release_nxt, level_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value; this is what makes the synchroniser a true 2-flop chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn_in;
      sync_2 <= sync_1;
    end
  end

  assign btn_s = sync_2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      level         <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      level         <= level_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    level_nxt   = level;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = ARM_PRESS;
          cnt_nxt   = '0;
        end
      end
      ARM_PRESS: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
          level_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt = ARM_RELEASE;
          cnt_nxt   = '0;
        end
      end
      ARM_RELEASE: begin
        // Mirror of ARM_PRESS; a bounce back high returns to HELD with level kept.
        if (btn_s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
          level_nxt   = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed bench for debounce_pulse (DEBOUNCE_CYCLES=4): reset, press, glitch,
// bounce, release and a downstream 3-bit counter driven by press_pulse.
module tb_debounce_pulse;

  logic clk;
  logic rst;
  logic btn_in;
  logic press_pulse;
  logic release_pulse;
  logic level;

  int n_cmp = 0;
  int n_mis = 0;

  // Downstream 3-bit counter enabled by press_pulse.
  logic [2:0] ext_count;
  logic       count_clr;

  debounce_pulse #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .level        (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (count_clr) ext_count <= 3'd0;
    else if (press_pulse) ext_count <= ext_count + 3'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  function automatic logic [63:0] ones(input int n);
    if (n >= 64) return '1;
    return (64'd1 << n) - 64'd1;
  endfunction

  // Drives pat[k] before edge k (k=0 is E0) and records what follows each edge.
  task automatic run(input logic [63:0] pat, input int n,
                     output int press_n, output int press_at,
                     output int rel_n, output int rel_at,
                     output int both_n, output logic [63:0] trace);
    press_n = 0; press_at = -1; rel_n = 0; rel_at = -1; both_n = 0; trace = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      btn_in = pat[k];
      @(posedge clk);
      #1;
      trace[k] = level;
      if (press_pulse === 1'b1) begin
        press_n++;
        if (press_at < 0) press_at = k;
      end
      if (release_pulse === 1'b1) begin
        rel_n++;
        if (rel_at < 0) rel_at = k;
      end
      if (press_pulse === 1'b1 && release_pulse === 1'b1) both_n++;
    end
  endtask

  task automatic test_reset;
    int pn, pa, rn, ra, bn;
    logic [63:0] tr;
    int pulses_in_reset;
    rst = 1'b0;
    btn_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({press_pulse, release_pulse, level} !== 3'b000) begin
      n_mis++;
      $display("FAIL reset_state: got %b want 000", {press_pulse, release_pulse, level});
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Bring the block to HELD, then hit it with a mid-cycle reset.
    run(64'hFFFF_FFFF_FFFF_FFFF, 12, pn, pa, rn, ra, bn, tr);
    n_cmp++;
    if (pa !== 6) begin
      n_mis++;
      $display("FAIL reset_prep_press_edge: got %0d want 6", pa);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({press_pulse, release_pulse, level} !== 3'b000) begin
      n_mis++;
      $display("FAIL reset_async: got %b want 000", {press_pulse, release_pulse, level});
    end
    pulses_in_reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (press_pulse !== 1'b0 || release_pulse !== 1'b0 || level !== 1'b0) pulses_in_reset++;
    end
    n_cmp++;
    if (pulses_in_reset !== 0) begin
      n_mis++;
      $display("FAIL reset_hold_quiet: got %0d active cycles want 0", pulses_in_reset);
    end
    rst = 1'b1;
    run(64'hFFFF_FFFF_FFFF_FFFF, 20, pn, pa, rn, ra, bn, tr);
    n_cmp++;
    if (pn !== 1 || pa !== 6) begin
      n_mis++;
      $display("FAIL post_reset_press: got count %0d edge %0d want count 1 edge 6", pn, pa);
    end
    n_cmp++;
    if (tr[19:0] !== 20'hFFFC0) begin
      n_mis++;
      $display("FAIL post_reset_level: got %h want fffc0", tr[19:0]);
    end
  endtask

  task automatic test_release;
    int pn, pa, rn, ra, bn;
    logic [63:0] tr;
    // Two-cycle low glitch while HELD must not release.
    run(64'hFFFF_FFFF_FFFF_FFFC, 12, pn, pa, rn, ra, bn, tr);
    n_cmp++;
    if (rn !== 0 || pn !== 0) begin
      n_mis++;
      $display("FAIL held_glitch_pulses: got press %0d release %0d want 0 0", pn, rn);
    end
    n_cmp++;
    if (tr[11:0] !== 12'hFFF) begin
      n_mis++;
      $display("FAIL held_glitch_level: got %h want fff", tr[11:0]);
    end
    run(64'h0, 20, pn, pa, rn, ra, bn, tr);
    n_cmp++;
    if (rn !== 1 || ra !== 6) begin
      n_mis++;
      $display("FAIL release_pulse: got count %0d edge %0d want count 1 edge 6", rn, ra);
    end
    n_cmp++;
    if (pn !== 0) begin
      n_mis++;
      $display("FAIL release_no_press: got %0d want 0", pn);
    end
    n_cmp++;
    if (tr[19:0] !== 20'h0003F) begin
      n_mis++;
      $display("FAIL release_level: got %h want 0003f", tr[19:0]);
    end
  endtask

  task automatic test_clean_press;
    int pn, pa, rn, ra, bn;
    logic [63:0] tr;
    run(64'hFFFF_FFFF_FFFF_FFFF, 20, pn, pa, rn, ra, bn, tr);
    n_cmp++;
    if (pn !== 1 || pa !== 6) begin
      n_mis++;
      $display("FAIL clean_press: got count %0d edge %0d want count 1 edge 6", pn, pa);
    end
    n_cmp++;
    if (rn !== 0 || bn !== 0) begin
      n_mis++;
      $display("FAIL clean_press_no_release: got release %0d both %0d want 0 0", rn, bn);
    end
    n_cmp++;
    if (tr !== (ones(20) & ~ones(6))) begin
      n_mis++;
      $display("FAIL clean_press_level: got %h want %h", tr, ones(20) & ~ones(6));
    end
    run(64'h0, 12, pn, pa, rn, ra, bn, tr);
    n_cmp++;
    if (rn !== 1) begin
      n_mis++;
      $display("FAIL clean_press_return: got %0d releases want 1", rn);
    end
  endtask

  task automatic test_glitch;
    int pn, pa, rn, ra, bn;
    logic [63:0] tr;
    run(64'h7, 20, pn, pa, rn, ra, bn, tr);
    n_cmp++;
    if (pn !== 0 || rn !== 0) begin
      n_mis++;
      $display("FAIL glitch_pulses: got press %0d release %0d want 0 0", pn, rn);
    end
    n_cmp++;
    if (tr !== 64'h0) begin
      n_mis++;
      $display("FAIL glitch_level: got %h want 0", tr);
    end
  endtask

  task automatic test_bounce;
    int pn, pa, rn, ra, bn;
    logic [63:0] tr;
    logic [63:0] pat;
    pat = '1;
    for (int i = 0; i < 10; i++) pat[i] = (i % 2 == 0);
    // Last 0->1 sample is edge 10, so acceptance lands on edge 16.
    run(pat, 30, pn, pa, rn, ra, bn, tr);
    n_cmp++;
    if (pn !== 1 || pa !== 16) begin
      n_mis++;
      $display("FAIL bounce_press: got count %0d edge %0d want count 1 edge 16", pn, pa);
    end
    n_cmp++;
    if (tr[29:0] !== 30'h3FFF_0000) begin
      n_mis++;
      $display("FAIL bounce_level: got %h want 3fff0000", tr[29:0]);
    end
    run(64'h0, 12, pn, pa, rn, ra, bn, tr);
    n_cmp++;
    if (rn !== 1 || ra !== 6) begin
      n_mis++;
      $display("FAIL bounce_return: got count %0d edge %0d want count 1 edge 6", rn, ra);
    end
  endtask

  task automatic test_integration;
    int pn, pa, rn, ra, bn;
    logic [63:0] tr;
    int bad_presses;
    @(negedge clk);
    count_clr = 1'b1;
    @(negedge clk);
    count_clr = 1'b0;
    bad_presses = 0;
    for (int p = 0; p < 9; p++) begin
      run(ones(10), 22, pn, pa, rn, ra, bn, tr);
      if (pn !== 1 || pa !== 6 || rn !== 1 || ra !== 16) bad_presses++;
      if (p == 4) begin
        n_cmp++;
        if (ext_count !== 3'd5) begin
          n_mis++;
          $display("FAIL counter_five: got %0d want 5", ext_count);
        end
      end
    end
    n_cmp++;
    if (ext_count !== 3'd1) begin
      n_mis++;
      $display("FAIL counter_wrap: got %0d want 1", ext_count);
    end
    n_cmp++;
    if (bad_presses !== 0) begin
      n_mis++;
      $display("FAIL press_cycle_timing: got %0d bad presses want 0", bad_presses);
    end
  endtask

  initial begin
    rst = 1'b0;
    btn_in = 1'b0;
    count_clr = 1'b1;
    test_reset();
    test_release();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_integration();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
